// File: rtl/framebuffer_arbiter_if.sv
// Bundle of reader, writer, RAM and page-status signals shared by the framebuffer arbiter.
// The master modport is the arbiter; the slave modport is its surroundings (scan, SPI, RAM).
interface framebuffer_arbiter_if #(
  parameter int unsigned BITS_PER_PIXEL = 16,
  parameter int unsigned ADDR_BITS      = 10
);
  logic                      rd_req;
  logic [ADDR_BITS-1:0]      rd_addr;
  logic                      rd_ack;
  logic                      rd_valid;
  logic [BITS_PER_PIXEL-1:0] rd_data;
  logic                      rd_frame_start;

  logic                      wr_req;
  logic [ADDR_BITS-1:0]      wr_addr;
  logic [BITS_PER_PIXEL-1:0] wr_data;
  logic                      wr_ack;
  logic                      wr_frame_done;

  logic [ADDR_BITS:0]        ram_addr;
  logic                      ram_we;
  logic [BITS_PER_PIXEL-1:0] ram_wdata;
  logic [BITS_PER_PIXEL-1:0] ram_rdata;

  logic                      display_page;
  logic                      swap_pending;
  logic                      frame_overrun;

  modport master (
    input  rd_req, rd_addr, rd_frame_start,
    input  wr_req, wr_addr, wr_data, wr_frame_done,
    input  ram_rdata,
    output rd_ack, rd_valid, rd_data,
    output wr_ack,
    output ram_addr, ram_we, ram_wdata,
    output display_page, swap_pending, frame_overrun
  );

  modport slave (
    output rd_req, rd_addr, rd_frame_start,
    output wr_req, wr_addr, wr_data, wr_frame_done,
    output ram_rdata,
    input  rd_ack, rd_valid, rd_data,
    input  wr_ack,
    input  ram_addr, ram_we, ram_wdata,
    input  display_page, swap_pending, frame_overrun
  );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Shares one single-port pixel RAM between the scan reader and the pixel writer, and owns
// the front/back page bit, flipping it only at display frame boundaries.
module framebuffer_arbiter #(
  parameter int unsigned BITS_PER_PIXEL = 16,
  parameter int unsigned ADDR_BITS      = 10,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input logic                   clk,
  input logic                   reset,
  framebuffer_arbiter_if.master bus
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    StShowing,
    StPending
  } page_state_e;

  page_state_e               state_q;
  logic                      display_page_q;
  logic                      rd_valid_q;
  logic                      frame_overrun_q;
  logic [CntW-1:0]           starve_cnt_q;
  logic [ADDR_BITS:0]        last_addr_q;
  logic [BITS_PER_PIXEL-1:0] last_wdata_q;

  logic                      writer_due;
  logic                      grant_rd;
  logic                      grant_wr;
  logic [ADDR_BITS:0]        ram_addr_d;
  logic [BITS_PER_PIXEL-1:0] ram_wdata_d;

  // Reader wins unless the writer has been refused STARVE_LIMIT times in a row.
  always_comb begin
    writer_due = (starve_cnt_q == CntMax);
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    if (!reset) begin
      grant_wr = bus.wr_req && (!bus.rd_req || writer_due);
      grant_rd = bus.rd_req && !grant_wr;
    end
  end

  // Idle cycles keep the RAM address/data lines parked on their previous values.
  always_comb begin
    ram_addr_d  = last_addr_q;
    ram_wdata_d = last_wdata_q;
    if (reset) begin
      ram_addr_d  = '0;
      ram_wdata_d = '0;
    end else if (grant_rd) begin
      ram_addr_d  = {display_page_q, bus.rd_addr};
    end else if (grant_wr) begin
      ram_addr_d  = {~display_page_q, bus.wr_addr};
      ram_wdata_d = bus.wr_data;
    end
  end

  assign bus.rd_ack        = grant_rd;
  assign bus.wr_ack        = grant_wr;
  assign bus.ram_we        = grant_wr;
  assign bus.ram_addr      = ram_addr_d;
  assign bus.ram_wdata     = ram_wdata_d;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = bus.ram_rdata;
  assign bus.display_page  = display_page_q;
  assign bus.swap_pending  = (state_q == StPending);
  assign bus.frame_overrun = frame_overrun_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StShowing;
      display_page_q  <= 1'b0;
      rd_valid_q      <= 1'b0;
      frame_overrun_q <= 1'b0;
      starve_cnt_q    <= '0;
      last_addr_q     <= '0;
      last_wdata_q    <= '0;
    end else begin
      rd_valid_q      <= grant_rd;
      frame_overrun_q <= 1'b0;
      last_addr_q     <= ram_addr_d;
      last_wdata_q    <= ram_wdata_d;

      if (bus.wr_req && !grant_wr) begin
        if (!writer_due) begin
          starve_cnt_q <= starve_cnt_q + 1'b1;
        end
      end else begin
        starve_cnt_q <= '0;
      end

      unique case (state_q)
        StShowing: begin
          if (bus.wr_frame_done && bus.rd_frame_start) begin
            display_page_q <= ~display_page_q;
          end else if (bus.wr_frame_done) begin
            state_q <= StPending;
          end
        end
        StPending: begin
          if (bus.rd_frame_start) begin
            // A frame finishing on the flip edge becomes the next pending frame.
            display_page_q <= ~display_page_q;
            state_q        <= bus.wr_frame_done ? StPending : StShowing;
          end else if (bus.wr_frame_done) begin
            frame_overrun_q <= 1'b1;
          end
        end
        default: state_q <= StShowing;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Randomised and directed checks of framebuffer_arbiter against a behavioural model of the
// grant rules, page flipping and a shadow copy of the pixel RAM.
module tb_framebuffer_arbiter;

  localparam int unsigned Bpp   = 16;
  localparam int unsigned Ab    = 10;
  localparam int unsigned Limit = 4;
  localparam int unsigned Words = 1 << (Ab + 1);

  logic clk = 1'b0;
  logic reset;
  logic ram_init = 1'b0;

  always #5 clk = ~clk;

  framebuffer_arbiter_if #(.BITS_PER_PIXEL(Bpp), .ADDR_BITS(Ab)) bus ();

  framebuffer_arbiter #(
    .BITS_PER_PIXEL(Bpp),
    .ADDR_BITS     (Ab),
    .STARVE_LIMIT  (Limit)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [Bpp-1:0] pattern(input int i);
    return 16'((i * 40503) ^ 16'h5a5a);
  endfunction

  // Synchronous single-port RAM with one-cycle read latency.
  logic [Bpp-1:0] ram [0:Words-1];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < int'(Words); i++) ram[i] <= pattern(i);
    end else if (bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [Bpp-1:0] ref_mem [0:Words-1];
  logic           m_page, m_pend, m_vld, m_ovr;
  int             m_streak;
  logic [Bpp-1:0] m_rdata, m_last_wdata;
  logic [Ab:0]    m_last_addr;
  logic           last_rd_ack, last_wr_ack;

  task automatic cyc(input logic rst, input logic rreq, input logic [Ab-1:0] raddr,
                     input logic wreq, input logic [Ab-1:0] waddr, input logic [Bpp-1:0] wdata,
                     input logic fs, input logic fd);
    logic           wr_wins, e_rd, e_wr;
    logic [Ab:0]    e_addr;
    logic [Bpp-1:0] e_wdata;
    @(negedge clk);
    reset              = rst;
    bus.rd_req         = rreq;
    bus.rd_addr        = raddr;
    bus.wr_req         = wreq;
    bus.wr_addr        = waddr;
    bus.wr_data        = wdata;
    bus.rd_frame_start = fs;
    bus.wr_frame_done  = fd;
    #1;
    wr_wins = wreq && (!rreq || m_streak >= int'(Limit));
    e_wr    = !rst && wr_wins;
    e_rd    = !rst && rreq && !wr_wins;
    e_addr  = m_last_addr;
    e_wdata = m_last_wdata;
    if (rst) begin
      e_addr  = '0;
      e_wdata = '0;
    end else if (e_rd) begin
      e_addr = {m_page, raddr};
    end else if (e_wr) begin
      e_addr  = {~m_page, waddr};
      e_wdata = wdata;
    end
    check_eq("rd_ack", 32'(bus.rd_ack), 32'(e_rd));
    check_eq("wr_ack", 32'(bus.wr_ack), 32'(e_wr));
    check_eq("ram_we", 32'(bus.ram_we), 32'(e_wr));
    check_eq("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
    check_eq("ram_wdata", 32'(bus.ram_wdata), 32'(e_wdata));
    check_eq("rd_valid", 32'(bus.rd_valid), 32'(m_vld));
    if (m_vld) check_eq("rd_data", 32'(bus.rd_data), 32'(m_rdata));
    check_eq("display_page", 32'(bus.display_page), 32'(m_page));
    check_eq("swap_pending", 32'(bus.swap_pending), 32'(m_pend));
    check_eq("frame_overrun", 32'(bus.frame_overrun), 32'(m_ovr));
    @(posedge clk);
    last_rd_ack = e_rd;
    last_wr_ack = e_wr;
    if (rst) begin
      m_page = 1'b0; m_pend = 1'b0; m_vld = 1'b0; m_ovr = 1'b0; m_streak = 0;
      m_last_addr = '0; m_last_wdata = '0;
    end else begin
      m_vld = e_rd;
      if (e_rd) m_rdata = ref_mem[e_addr];
      if (e_wr) ref_mem[e_addr] = wdata;
      m_last_addr  = e_addr;
      m_last_wdata = e_wdata;
      if (wreq && !e_wr) m_streak = (m_streak + 1 > int'(Limit)) ? int'(Limit) : m_streak + 1;
      else m_streak = 0;
      m_ovr = m_pend && fd && !fs;
      if (fs) begin
        if (m_pend || fd) m_page = ~m_page;
        m_pend = m_pend && fd;
      end else if (fd) begin
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  logic           r_req, w_req;
  logic [Ab-1:0]  r_addr, w_addr;
  logic [Bpp-1:0] w_data;

  initial begin
    for (int i = 0; i < int'(Words); i++) ref_mem[i] = pattern(i);
    m_page = 1'b0; m_pend = 1'b0; m_vld = 1'b0; m_ovr = 1'b0; m_streak = 0;
    m_rdata = '0; m_last_addr = '0; m_last_wdata = '0;
    reset = 1'b1;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_req = 1'b0; bus.wr_addr = '0;
    bus.wr_data = '0; bus.rd_frame_start = 1'b0; bus.wr_frame_done = 1'b0;
    ram_init = 1'b1;
    @(posedge clk);
    #1 ram_init = 1'b0;

    // Reset wins over active requests and frame pulses
    cyc(1'b1, 1'b1, 10'd3, 1'b1, 10'd4, 16'hbeef, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 10'd3, 1'b1, 10'd4, 16'hbeef, 1'b0, 1'b1);
    idle(2);

    // Continuous reads from the front page
    for (int a = 0; a < 4; a++) cyc(1'b0, 1'b1, 10'(a), 1'b0, '0, '0, 1'b0, 1'b0);
    idle(2);

    // Contending requests: four reads then one write, repeating
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 10'(i), 1'b1, 10'd5, 16'hc0de, 1'b0, 1'b0);
    idle(1);

    // Frame done, flip ten cycles later, then read the freshly written pixel
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(9);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 10'd5, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 10'd6, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(1);

    // Two frames finished without a flip: overrun pulse
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(2);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(2);
    // Flip and finish on the same edge while pending, then both in showing
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
    idle(2);

    // Reset while pending
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle(1);
    cyc(1'b1, 1'b1, 10'd2, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(2);

    // Random traffic; requesters hold their transaction until acked
    r_req = 1'b0; w_req = 1'b0; r_addr = '0; w_addr = '0; w_data = '0;
    last_rd_ack = 1'b0; last_wr_ack = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!r_req || last_rd_ack) begin
        r_req  = ($urandom_range(0, 3) != 0);
        r_addr = 10'($urandom_range(0, 15));
      end
      if (!w_req || last_wr_ack) begin
        w_req  = ($urandom_range(0, 2) != 0);
        w_addr = 10'($urandom_range(0, 15));
        w_data = 16'($urandom);
      end
      cyc(($urandom_range(0, 299) == 0), r_req, r_addr, w_req, w_addr, w_data,
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Single-clock arbiter and page-flip controller for the double-buffered HUB75 pixel RAM. It shares one synchronous single-port RAM between the display scan reader and the SPI-fed pixel writer. Read requests get priority, with a starvation guard so the writer still makes progress. It owns the front/back page bit and swaps pages only at display frame boundaries, so a partly written frame is never shown.

## Interface
- BITS_PER_PIXEL, 16, pixel word width.
- ADDR_BITS, 10, address width within one page; RAM address is ADDR_BITS+1 with the page in the MSB.
- STARVE_LIMIT, 4, consecutive refused write cycles before the writer overrides reader priority (≥1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  reader requests a pixel read.
- rd_addr  in  ADDR_BITS  read address within the display page.
- rd_ack  out  1  read accepted this cycle (combinational).
- rd_valid  out  1  rd_data valid (registered).
- rd_data  out  BITS_PER_PIXEL  read data (pass-through of ram_rdata).
- rd_frame_start  in  1  one-cycle pulse at the start of each display frame.
- wr_req  in  1  writer requests a pixel write.
- wr_addr  in  ADDR_BITS  write address within the back page.
- wr_data  in  BITS_PER_PIXEL  write data.
- wr_ack  out  1  write accepted this cycle (combinational).
- wr_frame_done  in  1  one-cycle pulse when the writer has completed a frame.
- ram_addr  out  ADDR_BITS+1  RAM address {page, addr}.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  BITS_PER_PIXEL  RAM write data.
- ram_rdata  in  BITS_PER_PIXEL  RAM read data, one cycle after the address is sampled.
- display_page  out  1  page being displayed.
- swap_pending  out  1  completed back frame is waiting for a flip.
- frame_overrun  out  1  one-cycle pulse when a frame completes while a swap is already pending.

## Operation
- Handshake (valid/ack): a requester holds req, addr and data stable until it sees ack high. Ack is high for exactly the cycle the RAM port carries the transaction. The requester may change addr/data or drop req at the following edge. Back-to-back transactions are allowed every cycle.
- Arbitration is combinational each cycle:
  - Only rd_req: grant read.
  - Only wr_req: grant write.
  - Both: grant write if starve_cnt == STARVE_LIMIT, otherwise grant read.
  - Neither: idle, with ram_we=0 and ram_addr/ram_wdata held at their last values.
- RAM drive:
  - Read grant: ram_addr={display_page, rd_addr}, ram_we=0.
  - Write grant: ram_addr={~display_page, wr_addr}, ram_we=1, ram_wdata=wr_data.
- Starvation counter starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments, saturating at STARVE_LIMIT, on edges where wr_req=1 and wr_ack=0.
  - Clears on edges where wr_ack=1 or wr_req=0.
- Read return: rd_valid is a register set at the edge ending an rd_ack cycle and cleared otherwise. rd_data=ram_rdata.
- Page FSM, states SHOWING and PENDING, on each edge:
  - SHOWING, wr_frame_done=1 only: go to PENDING.
  - SHOWING, wr_frame_done=1 and rd_frame_start=1: toggle display_page and stay in SHOWING.
  - SHOWING, rd_frame_start only: no change.
  - PENDING, rd_frame_start=1: toggle display_page and go to SHOWING. A wr_frame_done on the same edge is treated as the next frame, so the FSM goes to PENDING instead, with no overrun.
  - PENDING, wr_frame_done=1 only: pulse frame_overrun and stay in PENDING.
- swap_pending = (state == PENDING).
- Page selection uses the display_page value before the edge. A grant in the same cycle as a flip uses the old page.

## Timing
- Reset (synchronous, wins over all inputs):
  - Registered state: state=SHOWING, display_page=0, swap_pending=0, starve_cnt=0, rd_valid=0, frame_overrun=0.
  - Combinational outputs are not reset. During reset, rd_ack=wr_ack=0 and ram_we=0 are forced, with ram_addr=0 and ram_wdata=0.
  - Reset in the middle of a transaction drops it; no rd_valid follows.
- Latency: a read acked in cycle N gives rd_valid=1 in cycle N+1, with ram_rdata for that address.
- Write latency is 0 cycles: the RAM write occurs at the edge ending the wr_ack cycle.
- Throughput: one RAM access per cycle. With both requests held continuously, the grant pattern is STARVE_LIMIT reads then 1 write, repeating.
- Page flip: display_page changes at the edge ending the rd_frame_start cycle. The first read of the new frame after that edge uses the new page.

## Test plan
- Reset, then idle: display_page=0, swap_pending=0, rd_valid=0, ram_we=0, acks=0.
- Continuous reads only, rd_addr=0,1,2,3 on successive acks: rd_ack each cycle, with rd_valid and rd_data=mem[{0,addr}] one cycle later.
- rd_req and wr_req both held high, STARVE_LIMIT=4: ack pattern R,R,R,R,W repeating. The write lands at {1,wr_addr}.
- wr_frame_done then rd_frame_start 10 cycles later: swap_pending=1 for 10 cycles, then display_page=1. The next read goes to address {1,addr}.
- wr_frame_done twice without rd_frame_start: second pulse gives frame_overrun=1 for one cycle, swap_pending stays 1.
- wr_frame_done and rd_frame_start on the same edge in SHOWING: page toggles, swap_pending=0, no overrun. Reset asserted while PENDING: back to display_page=0, swap_pending=0.
